// File: rtl/data_io_pkg.sv
// Shared constants and types for the SPI file-download receiver.
package data_io_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    localparam logic [3:0] CNT_CMD_LAST      = 4'd7;
    localparam logic [3:0] CNT_BYTE_LAST     = 4'd15;
    localparam logic [3:0] CNT_PAYLOAD_FIRST = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD
    } spi_state_t;

endpackage

// File: rtl/data_io_fifo.sv
// Small synchronous FIFO with a look-ahead port on the entry behind the head.
module data_io_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         next,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign next    = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/data_io_stream.sv
// Oversampled SPI file-download receiver: decodes UIO commands, packs bytes into
// words and issues them through a FIFO onto a stallable memory write port.
module data_io_stream #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              sdi,
    output logic              downloading,
    output logic [7:0]        index,
    output logic [ADDR_W-1:0] size,
    output logic              overflow,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [DATA_W-1:0] ioctl_dout,
    input  logic              ioctl_wait
);

    import data_io_pkg::*;

    localparam int unsigned EW = ADDR_W + DATA_W;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] sck_sync, ss_sync, sdi_sync;
    logic       sck_d;
    logic       sck_rise, ss_s, sdi_s;

    spi_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] rx_byte;
    logic       pay_strobe;
    logic       pay_valid_q;
    logic [7:0] pay_byte_q;

    logic              is_start, is_end, is_data, is_index;
    logic              data_ok, end_ok, word_full;
    logic              push, xfer, dropped;
    logic [DATA_W-1:0] data_word, flush_word, push_word;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        lo_q;
    logic              lane_q;
    logic              ending_q;

    logic [EW-1:0] fifo_head, fifo_next;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            ss_sync  <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], sck};
            ss_sync  <= {ss_sync[0], ss};
            sdi_sync <= {sdi_sync[0], sdi};
            sck_d    <= sck_sync[1];
        end
    end

    assign ss_s     = ss_sync[1];
    assign sdi_s    = sdi_sync[1];
    assign sck_rise = sck_sync[1] && !sck_d;
    assign rx_byte  = {sr_q, sdi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            cmd_q       <= '0;
            pay_valid_q <= 1'b0;
            pay_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            cmd_q       <= cmd_d;
            pay_valid_q <= pay_strobe;
            pay_byte_q  <= rx_byte;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        cmd_d   = cmd_q;
        if (ss_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (sck_rise) begin
            sr_d = rx_byte[6:0];
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = 4'd1;
                end
                ST_CMD: begin
                    if (cnt_q == CNT_CMD_LAST) begin
                        cmd_d   = rx_byte;
                        cnt_d   = CNT_PAYLOAD_FIRST;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_PAYLOAD: begin
                    cnt_d = (cnt_q == CNT_BYTE_LAST) ? CNT_PAYLOAD_FIRST : cnt_q + 4'd1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pay_strobe = (state_q == ST_PAYLOAD) && !ss_s && sck_rise && (cnt_q == CNT_BYTE_LAST);
    end

    generate
        if (DATA_W == 8) begin : g_w8
            assign data_word  = pay_byte_q;
            assign flush_word = lo_q;
        end else begin : g_w16
            assign data_word  = {pay_byte_q, lo_q};
            assign flush_word = {8'h00, lo_q};
        end
    endgenerate

    always_comb begin
        is_start = 1'b0;
        is_end   = 1'b0;
        is_data  = 1'b0;
        is_index = 1'b0;
        if (pay_valid_q) begin
            case (cmd_q)
                UIO_FILE_TX: begin
                    is_start = pay_byte_q[0];
                    is_end   = !pay_byte_q[0];
                end
                UIO_FILE_TX_DAT: is_data  = 1'b1;
                UIO_FILE_INDEX:  is_index = 1'b1;
                default: ;
            endcase
        end
    end

    assign word_full = (DATA_W == 8) || lane_q;
    assign data_ok   = is_data && downloading && !ending_q;
    assign end_ok    = is_end && downloading && !ending_q;
    assign push      = (data_ok && word_full) || (end_ok && lane_q);
    assign push_word = data_ok ? data_word : flush_word;
    assign xfer      = ioctl_wr && !ioctl_wait;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign dropped   = push && fifo_full && !xfer;

    data_io_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (is_start),
        .push  (push),
        .din   ({addr_q, push_word}),
        .pop   (xfer),
        .head  (fifo_head),
        .next  (fifo_next),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= ADDR_W'(START_ADDR);
            lo_q        <= '0;
            lane_q      <= 1'b0;
            ending_q    <= 1'b0;
            downloading <= 1'b0;
            size        <= '0;
            overflow    <= 1'b0;
            index       <= '0;
        end else begin
            if (is_index) begin
                index <= pay_byte_q;
            end
            if (is_start) begin
                addr_q      <= ADDR_W'(START_ADDR);
                lane_q      <= 1'b0;
                ending_q    <= 1'b0;
                downloading <= 1'b1;
                size        <= '0;
                overflow    <= 1'b0;
            end else begin
                if (data_ok) begin
                    if (size != '1) begin
                        size <= size + ADDR_W'(1);
                    end
                    if (!word_full) begin
                        lo_q   <= pay_byte_q;
                        lane_q <= 1'b1;
                    end
                end
                if (push) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    lane_q <= 1'b0;
                    if (dropped) begin
                        overflow <= 1'b1;
                    end
                end
                if (end_ok) begin
                    if (!lane_q && fifo_empty && !ioctl_wr) begin
                        downloading <= 1'b0;
                    end else begin
                        ending_q <= 1'b1;
                    end
                end else if (ending_q && fifo_empty && !ioctl_wr) begin
                    downloading <= 1'b0;
                    ending_q    <= 1'b0;
                end
            end
        end
    end

    // The head stays in the FIFO until transferred; on a transfer the entry
    // behind it is loaded so consecutive words go out on consecutive cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ioctl_wr   <= 1'b0;
            ioctl_addr <= '0;
            ioctl_dout <= '0;
        end else if (is_start) begin
            ioctl_wr <= 1'b0;
        end else if (!ioctl_wr || xfer) begin
            if (xfer) begin
                if (fifo_count > CW'(1)) begin
                    ioctl_wr                 <= 1'b1;
                    {ioctl_addr, ioctl_dout} <= fifo_next;
                end else begin
                    ioctl_wr <= 1'b0;
                end
            end else if (!fifo_empty) begin
                ioctl_wr                 <= 1'b1;
                {ioctl_addr, ioctl_dout} <= fifo_head;
            end
        end
    end

endmodule

// File: tb/tb_data_io_stream.sv
// Scoreboard bench: an 8-bit (START_ADDR 0x100) and a 16-bit instance share one SPI stream.
module tb_data_io_stream;

    logic clk = 1'b0;
    logic reset, sck, ss, sdi;
    logic wait8, wait16;

    logic        dl8, dl16, ov8, ov16, wr8, wr16;
    logic [7:0]  idx8, idx16;
    logic [15:0] size8, size16, addr8, addr16;
    logic [7:0]  dout8;
    logic [15:0] dout16;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t q8[$];
    wr_t q16[$];
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    data_io_stream #(.ADDR_W(16), .DATA_W(8), .START_ADDR(32'h100), .FIFO_DEPTH(4)) u8 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl8), .index(idx8), .size(size8), .overflow(ov8),
        .ioctl_wr(wr8), .ioctl_addr(addr8), .ioctl_dout(dout8), .ioctl_wait(wait8)
    );

    data_io_stream #(.ADDR_W(16), .DATA_W(16), .START_ADDR(0), .FIFO_DEPTH(4)) u16 (
        .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
        .downloading(dl16), .index(idx16), .size(size16), .overflow(ov16),
        .ioctl_wr(wr16), .ioctl_addr(addr16), .ioctl_dout(dout16), .ioctl_wait(wait16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (wr8 && !wait8) begin
            if (q8.size() == 0) begin
                check_eq("wr8_extra", {31'd0, wr8}, 32'd0);
            end else begin
                e = q8.pop_front();
                check_eq("wr8_addr", {16'd0, addr8}, {16'd0, e.addr});
                check_eq("wr8_data", {24'd0, dout8}, {16'd0, e.data});
            end
        end
        if (wr16 && !wait16) begin
            if (q16.size() == 0) begin
                check_eq("wr16_extra", {31'd0, wr16}, 32'd0);
            end else begin
                e = q16.pop_front();
                check_eq("wr16_addr", {16'd0, addr16}, {16'd0, e.addr});
                check_eq("wr16_data", {16'd0, dout16}, {16'd0, e.data});
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp8(input logic [15:0] a, input logic [15:0] d);
        q8.push_back('{a, d});
    endtask

    task automatic exp16(input logic [15:0] a, input logic [15:0] d);
        q16.push_back('{a, d});
    endtask

    task automatic spi_bits(input logic [7:0] b, input int unsigned nbits);
        for (int i = 0; i < int'(nbits); i++) begin
            sdi = b[7-i];
            tick(4);
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
    endtask

    task automatic frame_open(input logic [7:0] cmd);
        ss = 1'b0;
        tick(4);
        spi_bits(cmd, 8);
    endtask

    task automatic frame_close();
        tick(4);
        ss = 1'b1;
        tick(8);
    endtask

    task automatic send1(input logic [7:0] cmd, input logic [7:0] b);
        frame_open(cmd);
        spi_bits(b, 8);
        frame_close();
    endtask

    task automatic wait_drain(input string tag);
        int unsigned k = 0;
        while ((q8.size() != 0 || q16.size() != 0) && k < 1000) begin
            tick(1);
            k++;
        end
        tick(3);
        check_eq({tag, "_q8"}, q8.size(), 0);
        check_eq({tag, "_q16"}, q16.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        reset = 1'b1; sck = 1'b0; ss = 1'b1; sdi = 1'b0; wait8 = 1'b0; wait16 = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_dl", {31'd0, dl8}, 0);
        check_eq("rst_size", {16'd0, size8}, 0);
        check_eq("rst_wr", {31'd0, wr8}, 0);
        check_eq("rst_addr", {16'd0, addr8}, 0);
        check_eq("rst_ov", {31'd0, ov8}, 0);
        tick(2);

        // index, start, three bytes, end
        send1(8'h55, 8'h05);
        send1(8'h53, 8'h01);
        check_eq("t1_dl8_up", {31'd0, dl8}, 1);
        check_eq("t1_dl16_up", {31'd0, dl16}, 1);
        frame_open(8'h54);
        exp8(16'h100, 16'h11); spi_bits(8'h11, 8);
        exp8(16'h101, 16'h22); exp16(16'h0, 16'h2211); spi_bits(8'h22, 8);
        exp8(16'h102, 16'h33); spi_bits(8'h33, 8);
        frame_close();
        exp16(16'h1, 16'h0033);
        send1(8'h53, 8'h00);
        wait_drain("t1");
        check_eq("t1_index8", {24'd0, idx8}, 32'h05);
        check_eq("t1_index16", {24'd0, idx16}, 32'h05);
        check_eq("t1_size8", {16'd0, size8}, 3);
        check_eq("t1_size16", {16'd0, size16}, 3);
        check_eq("t1_dl8_down", {31'd0, dl8}, 0);
        check_eq("t1_dl16_down", {31'd0, dl16}, 0);

        // odd byte count flush in 16-bit
        send1(8'h53, 8'h01);
        frame_open(8'h54);
        exp8(16'h100, 16'hAA); spi_bits(8'hAA, 8);
        exp8(16'h101, 16'hBB); exp16(16'h0, 16'hBBAA); spi_bits(8'hBB, 8);
        exp8(16'h102, 16'hCC); spi_bits(8'hCC, 8);
        frame_close();
        exp16(16'h1, 16'h00CC);
        send1(8'h53, 8'h00);
        wait_drain("t2");
        check_eq("t2_size16", {16'd0, size16}, 3);
        check_eq("t2_dl16", {31'd0, dl16}, 0);

        // overflow with the consumer stalled
        wait8 = 1'b1;
        send1(8'h53, 8'h01);
        frame_open(8'h54);
        for (int k = 1; k <= 6; k++) begin
            b = 8'(k);
            if (k <= 4) exp8(16'h100 + 16'(k - 1), {8'h00, b});
            if (k % 2 == 0) exp16(16'(k / 2 - 1), {b, b - 8'd1});
            spi_bits(b, 8);
        end
        frame_close();
        check_eq("t3_ov8", {31'd0, ov8}, 1);
        check_eq("t3_ov16", {31'd0, ov16}, 0);
        check_eq("t3_size8", {16'd0, size8}, 6);
        check_eq("t3_hold_wr", {31'd0, wr8}, 1);
        check_eq("t3_hold_addr", {16'd0, addr8}, 32'h100);
        check_eq("t3_hold_data", {24'd0, dout8}, 32'h01);
        wait8 = 1'b0;
        wait_drain("t3a");
        check_eq("t3_size8_after", {16'd0, size8}, 6);
        frame_open(8'h54);
        exp8(16'h106, 16'h07); spi_bits(8'h07, 8);
        frame_close();
        exp16(16'h3, 16'h0007);
        send1(8'h53, 8'h00);
        wait_drain("t3b");
        check_eq("t3_size16", {16'd0, size16}, 7);

        // partial byte discarded on deselect
        send1(8'h53, 8'h01);
        frame_open(8'h54);
        spi_bits(8'hF0, 4);
        frame_close();
        frame_open(8'h54);
        exp8(16'h100, 16'h7E); spi_bits(8'h7E, 8);
        frame_close();
        exp16(16'h0, 16'h007E);
        send1(8'h53, 8'h00);
        wait_drain("t4");
        check_eq("t4_size8", {16'd0, size8}, 1);
        check_eq("t4_size16", {16'd0, size16}, 1);

        // restart mid-download discards stale words
        wait8 = 1'b1;
        send1(8'h53, 8'h01);
        frame_open(8'h54);
        for (int k = 1; k <= 6; k++) begin
            b = 8'hA0 + 8'(k);
            if (k % 2 == 0) exp16(16'(k / 2 - 1), {b, b - 8'd1});
            spi_bits(b, 8);
        end
        frame_close();
        check_eq("t5_ov8_set", {31'd0, ov8}, 1);
        send1(8'h53, 8'h01);
        check_eq("t5_ov8_clr", {31'd0, ov8}, 0);
        check_eq("t5_size8", {16'd0, size8}, 0);
        check_eq("t5_wr8", {31'd0, wr8}, 0);
        check_eq("t5_dl8", {31'd0, dl8}, 1);
        wait8 = 1'b0;
        tick(10);
        frame_open(8'h54);
        exp8(16'h100, 16'h5A); spi_bits(8'h5A, 8);
        frame_close();
        exp16(16'h0, 16'h005A);
        send1(8'h53, 8'h00);
        wait_drain("t5");
        check_eq("t5_dl8_down", {31'd0, dl8}, 0);

        // reset mid-download with words pending
        wait8 = 1'b1;
        send1(8'h53, 8'h01);
        frame_open(8'h54);
        spi_bits(8'hC1, 8);
        exp16(16'h0, 16'hC2C1); spi_bits(8'hC2, 8);
        spi_bits(8'hC3, 8);
        frame_close();
        check_eq("t6_wr8_pre", {31'd0, wr8}, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_dl8", {31'd0, dl8}, 0);
        check_eq("t6_idx8", {24'd0, idx8}, 0);
        check_eq("t6_size8", {16'd0, size8}, 0);
        check_eq("t6_wr8", {31'd0, wr8}, 0);
        check_eq("t6_addr8", {16'd0, addr8}, 0);
        check_eq("t6_dout8", {24'd0, dout8}, 0);
        check_eq("t6_dl16", {31'd0, dl16}, 0);
        tick(1);
        reset = 1'b0;
        wait8 = 1'b0;
        tick(20);
        check_eq("t6_wr8_post", {31'd0, wr8}, 0);
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
